global_state_table: RTL and testbench
=====================================

Name: global_state_table

Overview:
- Global variable-assignment table for the SAT BCP accelerator.
- Sits between the UC (unit clause) arbiter and the BCP engines.
- Pops implied unit literals from the UC arbiter queue and records each literal's variable assignment.
- Gives the BCP engines a combinational truth-value lookup for every literal of the current clause, plus a per-engine "update finished" indication.

Parameters:
- NUM_ENGINE, default 4 (codebase macro `NUM_ENGINE): number of BCP engines.
- CLA_LENGTH, default 3 (macro `CLA_LENGTH): literals per clause.
- LIT_WIDTH, default 32: lit_t width, signed two's complement.
- NUM_VARS, default 64: table depth; valid variable indices are 1..NUM_VARS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- bcp2gst_curr_cla  in  CLA_LENGTH*LIT_WIDTH  clause to look up; slot k is bits [k*LIT_WIDTH +: LIT_WIDTH], slot 0 is the LSBs.
- bcp2gst_curr_cla_valid  in  1  lookup request valid.
- bcp2gst_curr_state  in  NUM_ENGINE*2  bcp_state_t per engine: IDLE=0, PROC=1, DONE=2.
- gst2bcp_lit_state  out  CLA_LENGTH*2  lit_state_t per clause slot: UNDEF=0, TRUE=1, FALSE=2.
- gst2bcp_update_finish  out  NUM_ENGINE  per-engine update-complete flag.
- ucarb2gst_lit  in  LIT_WIDTH  head literal of the UC queue (show-ahead).
- ucarb2gst_empty  in  1  UC queue empty.
- gst2ucarb_pop  out  1  pop / consume the head literal.

Behaviour:
- Literal encoding:
  - lit > 0 means variable lit = 1; lit < 0 means variable |lit| = 0.
  - lit = 0 is null.
  - |lit| >= NUM_VARS is out of range and treated as null.
- Storage: per variable, a 2-bit value UNASSIGNED / ONE / ZERO.
- Reset (rst_n low, asynchronous):
  - All entries become UNASSIGNED.
  - gst2ucarb_pop=0, gst2bcp_update_finish=0.
  - gst2bcp_lit_state is all UNDEF while in reset.
- Update phase: update_phase = no engine is in PROC.
- Pop, combinational: gst2ucarb_pop = rst_n & update_phase & ~ucarb2gst_empty.
- Write, at the rising edge where pop=1:
  - The entry for |ucarb2gst_lit| is written to ONE (positive literal) or ZERO (negative literal).
  - The write happens only if the entry is UNASSIGNED. An already-assigned variable is left unchanged (first assignment wins), including a conflicting assignment.
  - A null literal is consumed with no write.
  - Throughput: one literal per cycle.
- Lookup, combinational, same cycle:
  - For each slot k: if cla_valid=0, or the slot is null, or the variable is UNASSIGNED, the result is UNDEF.
  - Otherwise the result is TRUE when the stored value matches the literal's sign, else FALSE.
  - No write bypass: a lookup in the same cycle as a write returns the pre-edge value.
- Update finish, registered:
  - gst2bcp_update_finish[i] goes to 1 at an edge where engine i is in DONE, update_phase=1, ucarb2gst_empty=1 and no pop occurred.
  - It returns to 0 at an edge where engine i is not in DONE, or where a pop occurs.
- Engine states other than 0–2 are treated as IDLE.
- Any engine in PROC blocks popping, even while the queue is non-empty.
- Reset asserted mid-operation clears the table immediately; no partial writes persist.

Test Plan:
- Reset, then idle 5 cycles with all engines IDLE and queue empty -> pop=0, update_finish=0, lit_state all UNDEF.
- Engines DONE; head 3, 4, 5 on consecutive cycles with empty=0 -> pop=1 each cycle; vars 3, 4, 5 become ONE; then set empty=1 -> update_finish all 1 one cycle later.
- After the above, engines PROC, cla={3,4,5} (slot2=3, slot1=4, slot0=5), valid=1 -> lit_state = TRUE, TRUE, TRUE in the same cycle.
- Lookup cla={-3,7,0}, valid=1 -> slot2 FALSE, slot1 UNDEF, slot0 UNDEF; with valid=0 -> all UNDEF.
- One engine PROC, queue non-empty with head -9 -> pop=0, var 9 unchanged; move engine to DONE -> pop=1, var 9 = ZERO; then push 9 -> consumed, var 9 stays ZERO (lookup of 9 = FALSE).
- Write 6, assert rst_n=0 asynchronously mid-cycle -> lookup of 6 becomes UNDEF at once, pop=0; after release, table is empty.

Source files
------------

// File: rtl/global_state_table.sv
// Global variable-assignment table for the SAT BCP accelerator.
// Consumes implied literals from the UC arbiter queue and answers clause lookups for the BCP engines.
module global_state_table #(
  parameter int unsigned NUM_ENGINE = 4,
  parameter int unsigned CLA_LENGTH = 3,
  parameter int unsigned LIT_WIDTH  = 32,
  parameter int unsigned NUM_VARS   = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CLA_LENGTH*LIT_WIDTH-1:0] bcp2gst_curr_cla,
  input  logic                            bcp2gst_curr_cla_valid,
  input  logic [NUM_ENGINE*2-1:0]         bcp2gst_curr_state,
  output logic [CLA_LENGTH*2-1:0]         gst2bcp_lit_state,
  output logic [NUM_ENGINE-1:0]           gst2bcp_update_finish,
  input  logic [LIT_WIDTH-1:0]            ucarb2gst_lit,
  input  logic                            ucarb2gst_empty,
  output logic                            gst2ucarb_pop
);

  localparam int unsigned IdxW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  localparam logic [1:0] BcpIdle = 2'd0;
  localparam logic [1:0] BcpProc = 2'd1;
  localparam logic [1:0] BcpDone = 2'd2;

  localparam logic [1:0] VarUnassigned = 2'd0;
  localparam logic [1:0] VarOne        = 2'd1;
  localparam logic [1:0] VarZero       = 2'd2;

  localparam logic [1:0] LitUndef = 2'd0;
  localparam logic [1:0] LitTrue  = 2'd1;
  localparam logic [1:0] LitFalse = 2'd2;

  logic [1:0] tbl_q [NUM_VARS];

  logic                  update_phase;
  logic [LIT_WIDTH-1:0]  wr_mag;
  logic                  wr_neg;
  logic                  wr_ok;
  logic [IdxW-1:0]       wr_idx;
  logic [NUM_ENGINE-1:0] finish_d;
  logic [NUM_ENGINE-1:0] finish_q;

  // Any engine still propagating blocks table updates.
  always_comb begin
    update_phase = 1'b1;
    for (int i = 0; i < int'(NUM_ENGINE); i++) begin
      if (bcp2gst_curr_state[2*i +: 2] == BcpProc) update_phase = 1'b0;
    end
  end

  assign gst2ucarb_pop = rst_n & update_phase & ~ucarb2gst_empty;

  // Null and out-of-range literals are popped but never written.
  assign wr_neg = ucarb2gst_lit[LIT_WIDTH-1];
  assign wr_mag = wr_neg ? (~ucarb2gst_lit + LIT_WIDTH'(1)) : ucarb2gst_lit;
  assign wr_ok  = (wr_mag != '0) && (wr_mag < LIT_WIDTH'(NUM_VARS));
  assign wr_idx = wr_mag[IdxW-1:0];

  // First assignment wins; later or conflicting literals for the same variable are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < int'(NUM_VARS); v++) tbl_q[v] <= VarUnassigned;
    end else if (gst2ucarb_pop && wr_ok && (tbl_q[wr_idx] == VarUnassigned)) begin
      tbl_q[wr_idx] <= wr_neg ? VarZero : VarOne;
    end
  end

  for (genvar k = 0; k < int'(CLA_LENGTH); k++) begin : g_slot
    logic [LIT_WIDTH-1:0] lit;
    logic [LIT_WIDTH-1:0] mag;
    logic                 neg;
    logic                 ok;
    logic [1:0]           val;

    assign lit = bcp2gst_curr_cla[k*LIT_WIDTH +: LIT_WIDTH];
    assign neg = lit[LIT_WIDTH-1];
    assign mag = neg ? (~lit + LIT_WIDTH'(1)) : lit;
    assign ok  = (mag != '0) && (mag < LIT_WIDTH'(NUM_VARS));
    assign val = tbl_q[mag[IdxW-1:0]];

    assign gst2bcp_lit_state[2*k +: 2] =
        (!rst_n || !bcp2gst_curr_cla_valid || !ok || (val == VarUnassigned)) ? LitUndef :
        (((val == VarZero) == neg) ? LitTrue : LitFalse);
  end

  always_comb begin
    finish_d = finish_q;
    for (int i = 0; i < int'(NUM_ENGINE); i++) begin
      if ((bcp2gst_curr_state[2*i +: 2] != BcpDone) || gst2ucarb_pop) begin
        finish_d[i] = 1'b0;
      end else if (update_phase && ucarb2gst_empty) begin
        finish_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) finish_q <= '0;
    else        finish_q <= finish_d;
  end

  assign gst2bcp_update_finish = finish_q;

  // Idle encoding is implicit: anything not PROC or DONE behaves as IDLE.
  logic unused_idle;
  assign unused_idle = ^BcpIdle;

endmodule

// File: tb/tb_global_state_table.sv
// Directed bench for global_state_table: lookup vector table plus pop/finish/reset sequences.
module tb_global_state_table;

  localparam logic [7:0] AllIdle = 8'b00_00_00_00;
  localparam logic [7:0] AllDone = 8'b10_10_10_10;
  localparam logic [7:0] AllProc = 8'b01_01_01_01;
  localparam logic [7:0] E0Proc  = 8'b10_10_10_01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] cla = '0;
  logic        cla_valid = 1'b0;
  logic [7:0]  state = AllIdle;
  logic [5:0]  lit_state;
  logic [3:0]  finish;
  logic [31:0] uc_lit = '0;
  logic        uc_empty = 1'b1;
  logic        pop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  global_state_table dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bcp2gst_curr_cla       (cla),
    .bcp2gst_curr_cla_valid (cla_valid),
    .bcp2gst_curr_state     (state),
    .gst2bcp_lit_state      (lit_state),
    .gst2bcp_update_finish  (finish),
    .ucarb2gst_lit          (uc_lit),
    .ucarb2gst_empty        (uc_empty),
    .gst2ucarb_pop          (pop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] l2, input logic [31:0] l1, input logic [31:0] l0,
                        input logic v);
    cla = {l2, l1, l0};
    cla_valid = v;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] l2;
    logic [31:0] l1;
    logic [31:0] l0;
    logic        valid;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // slot encoding per 2 bits: 0 UNDEF, 1 TRUE, 2 FALSE; slot2 in the MSBs
    vecs[0] = '{"all_true",   32'd3,  32'd4,  32'd5,  1'b1, 6'b01_01_01};
    vecs[1] = '{"neg3_7_0",   -32'sd3, 32'd7, 32'd0,  1'b1, 6'b10_00_00};
    vecs[2] = '{"invalid",    -32'sd3, 32'd7, 32'd0,  1'b0, 6'b00_00_00};
    vecs[3] = '{"oor_neg",    32'd64, -32'sd4, -32'sd5, 1'b1, 6'b00_10_10};
    vecs[4] = '{"oor_unasg",  -32'sd64, 32'd3, -32'sd1, 1'b1, 6'b00_01_00};
    vecs[5] = '{"minint",     32'h8000_0000, 32'd5, 32'd4, 1'b1, 6'b00_01_01};

    // Reset and idle
    #12 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("idle_pop", 32'(pop), 32'd0);
    check("idle_finish", 32'(finish), 32'd0);
    lookup(32'd3, 32'd4, 32'd5, 1'b1);
    check("idle_lookup", 32'(lit_state), 32'd0);
    cla_valid = 1'b0;

    // Back-to-back pops of 3, 4, 5 with all engines DONE
    state = AllDone;
    for (int i = 3; i <= 5; i++) begin
      uc_lit = 32'(i);
      uc_empty = 1'b0;
      #1;
      check($sformatf("pop_%0d", i), 32'(pop), 32'd1);
      @(negedge clk);
      check($sformatf("finish_low_%0d", i), 32'(finish), 32'd0);
    end
    uc_empty = 1'b1;
    #1;
    check("pop_empty", 32'(pop), 32'd0);
    @(negedge clk);
    check("finish_set", 32'(finish), 32'hF);

    // Lookup vector table with all engines in PROC
    state = AllProc;
    for (int i = 0; i < 6; i++) begin
      lookup(vecs[i].l2, vecs[i].l1, vecs[i].l0, vecs[i].valid);
      check(vecs[i].name, 32'(lit_state), 32'(vecs[i].exp));
    end
    @(negedge clk);
    check("finish_clr_proc", 32'(finish), 32'd0);

    // Engine 0 in PROC blocks the pop of -9
    state = E0Proc;
    uc_lit = -32'sd9;
    uc_empty = 1'b0;
    #1;
    check("blocked_pop", 32'(pop), 32'd0);
    @(negedge clk);
    lookup(32'd9, 32'd0, 32'd0, 1'b1);
    check("blocked_var9", 32'(lit_state), 32'b00_0000);
    state = AllDone;
    #1;
    check("unblocked_pop", 32'(pop), 32'd1);
    check("no_bypass", 32'(lit_state), 32'b00_0000);
    @(negedge clk);
    check("var9_zero", 32'(lit_state), 32'b10_0000);
    // Conflicting +9 is consumed but ignored
    uc_lit = 32'd9;
    #1;
    check("conflict_pop", 32'(pop), 32'd1);
    @(negedge clk);
    uc_empty = 1'b1;
    #1;
    check("var9_kept", 32'(lit_state), 32'b10_0000);
    // Null literal consumed without a write
    uc_lit = 32'd0;
    uc_empty = 1'b0;
    #1;
    check("null_pop", 32'(pop), 32'd1);
    @(negedge clk);
    uc_empty = 1'b1;
    lookup(32'd9, 32'd0, 32'd1, 1'b1);
    check("null_nowrite", 32'(lit_state), 32'b10_0000);

    // Write 6, then asynchronous reset mid-cycle
    uc_lit = 32'd6;
    uc_empty = 1'b0;
    @(negedge clk);
    lookup(32'd6, 32'd3, 32'd9, 1'b1);
    check("var6_true", 32'(lit_state), 32'b01_01_10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_lookup", 32'(lit_state), 32'd0);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    uc_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_lookup", 32'(lit_state), 32'd0);
    @(negedge clk);
    check("post_rst_finish", 32'(finish), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
